pid_cntrl_param: RTL and testbench

//  Parametrised balance PID controller, successor to the fixed-width Segway PID.

---
 rtl/pid_cntrl_param.sv | 169 ++++++++++++++++
 tb/tb_pid_cntrl_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pid_cntrl_param.sv
// rtl/pid_cntrl_param.sv - parametrised balance PID with slow-start ramp and integrator anti-windup
// Two-stage pipeline: stage 1 registers P/I/D terms, stage 2 sums, saturates and scales by ramp state.
module pid_cntrl_param #(
  parameter int ERR_W    = 10,
  parameter int INT_W    = 18,
  parameter int OUT_W    = 12,
  parameter int GAIN_W   = 6,
  parameter int D_DEPTH  = 4,
  parameter int I_SHIFT  = 1,
  parameter int FAST_SIM = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic [15:0]             err,
  input  logic [GAIN_W-1:0]       P_gain,
  input  logic [GAIN_W-1:0]       D_gain,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic                    hold,
  output logic signed [OUT_W-1:0] cntrl,
  output logic                    cntrl_vld,
  output logic [7:0]              ss_tmr,
  output logic                    int_sat
);

  localparam int P_W   = ERR_W + GAIN_W + 1;
  localparam int D_W   = ERR_W + GAIN_W + 2;
  localparam int W_A   = (OUT_W + 4 > D_W) ? OUT_W + 4 : D_W;
  localparam int SUM_W = ((W_A > INT_W) ? W_A : INT_W) + 2;
  localparam int SC_W  = OUT_W + 9;
  localparam logic [26:0] TMR_INC = (FAST_SIM != 0) ? 27'd256 : 27'd1;

  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;

  state_t                  state_q, state_d;
  logic [26:0]             tmr_q, tmr_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic                    int_sat_q, int_sat_d;
  logic signed [ERR_W-1:0] hist_q [D_DEPTH];
  logic signed [ERR_W-1:0] hist_d [D_DEPTH];
  logic signed [P_W-1:0]   p_q, p_d;
  logic signed [D_W-1:0]   dterm_q, dterm_d;
  logic signed [INT_W-1:0] iterm_q, iterm_d;
  logic                    s1_vld_q, s1_vld_d;
  logic signed [OUT_W-1:0] cntrl_q, cntrl_d;
  logic                    cntrl_vld_q, cntrl_vld_d;

  logic signed [ERR_W-1:0] err_sat;
  logic signed [INT_W:0]   int_sum;
  logic signed [P_W-1:0]   p_err, p_gain_x;
  logic signed [D_W-1:0]   d_diff, d_gain_x;
  logic signed [SUM_W-1:0] pid_sum;
  logic signed [OUT_W-1:0] pid_sat;
  logic signed [SC_W-1:0]  sc_pid, sc_tmr, sc_prod;

  // Operands are widened by hand so every product and sum is computed at its final width.
  always_comb begin
    if (&err[15:ERR_W-1] || ~|err[15:ERR_W-1]) err_sat = err[ERR_W-1:0];
    else err_sat = err[15] ? {1'b1, {(ERR_W-1){1'b0}}} : {1'b0, {(ERR_W-1){1'b1}}};
    int_sum  = {integ_q[INT_W-1], integ_q} + {{(INT_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};
    p_err    = {{(P_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
    p_gain_x = {{(P_W-GAIN_W){1'b0}}, P_gain};
    d_diff   = {{(D_W-ERR_W){err_sat[ERR_W-1]}}, err_sat}
             - {{(D_W-ERR_W){hist_q[D_DEPTH-1][ERR_W-1]}}, hist_q[D_DEPTH-1]};
    d_gain_x = {{(D_W-GAIN_W){1'b0}}, D_gain};
  end

  always_comb begin
    integ_d   = integ_q;
    int_sat_d = int_sat_q;
    hist_d    = hist_q;
    p_d       = p_q;
    dterm_d   = dterm_q;
    iterm_d   = iterm_q;
    s1_vld_d  = 1'b0;
    if (rider_off) begin
      integ_d   = '0;
      int_sat_d = 1'b0;
      for (int i = 0; i < D_DEPTH; i++) hist_d[i] = '0;
    end else if (vld) begin
      if (!hold) begin
        if (int_sum[INT_W] != int_sum[INT_W-1]) begin
          int_sat_d = 1'b1;
        end else begin
          integ_d   = int_sum[INT_W-1:0];
          int_sat_d = 1'b0;
        end
      end
      p_d     = p_err * p_gain_x;
      dterm_d = d_diff * d_gain_x;
      iterm_d = integ_d >>> I_SHIFT;
      for (int i = D_DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = err_sat;
      s1_vld_d  = 1'b1;
    end
  end

  always_comb begin
    pid_sum = {{(SUM_W-P_W){p_q[P_W-1]}}, p_q}
            + {{(SUM_W-D_W){dterm_q[D_W-1]}}, dterm_q}
            + {{(SUM_W-INT_W){iterm_q[INT_W-1]}}, iterm_q};
    if (&pid_sum[SUM_W-1:OUT_W-1] || ~|pid_sum[SUM_W-1:OUT_W-1]) pid_sat = pid_sum[OUT_W-1:0];
    else pid_sat = pid_sum[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    sc_pid  = {{(SC_W-OUT_W){pid_sat[OUT_W-1]}}, pid_sat};
    sc_tmr  = {{(SC_W-8){1'b0}}, ss_tmr};
    sc_prod = sc_pid * sc_tmr;
    cntrl_d     = cntrl_q;
    cntrl_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      case (state_q)
        IDLE:    cntrl_d = '0;
        RAMP:    cntrl_d = OUT_W'(sc_prod >>> 8);
        default: cntrl_d = pid_sat;
      endcase
    end
  end

  // Timer parks once bits [26:8] are all ones so ss_tmr sits at 8'hFF.
  always_comb begin
    tmr_d = tmr_q;
    if (!pwr_up) tmr_d = '0;
    else if (!(&tmr_q[26:8])) tmr_d = tmr_q + TMR_INC;
    state_d = state_q;
    if (!pwr_up) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RAMP;
        RAMP:    if (ss_tmr == 8'hFF) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      integ_q     <= '0;
      int_sat_q   <= 1'b0;
      hist_q      <= '{default: '0};
      p_q         <= '0;
      dterm_q     <= '0;
      iterm_q     <= '0;
      s1_vld_q    <= 1'b0;
      cntrl_q     <= '0;
      cntrl_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      integ_q     <= integ_d;
      int_sat_q   <= int_sat_d;
      hist_q      <= hist_d;
      p_q         <= p_d;
      dterm_q     <= dterm_d;
      iterm_q     <= iterm_d;
      s1_vld_q    <= s1_vld_d;
      cntrl_q     <= cntrl_d;
      cntrl_vld_q <= cntrl_vld_d;
    end
  end

  assign ss_tmr    = tmr_q[26:19];
  assign cntrl     = cntrl_q;
  assign cntrl_vld = cntrl_vld_q;
  assign int_sat   = int_sat_q;

endmodule

// File: tb/tb_pid_cntrl_param.sv
// tb/tb_pid_cntrl_param.sv - directed self-checking bench for pid_cntrl_param
module tb_pid_cntrl_param;
  logic clk = 1'b0;
  logic rst_n, vld, pwr_up, rider_off, hold;
  logic [15:0] err;
  logic [5:0] P_gain, D_gain;
  logic signed [11:0] cntrl;
  logic cntrl_vld, int_sat;
  logic [7:0] ss_tmr;
  int n_chk = 0;
  int n_err = 0;
  int pulses;
  int d_err [9] = '{0, 0, 0, 0, 100, 0, 0, 0, 0};
  int d_exp [9] = '{0, 0, 0, 0, 250, 50, 50, 50, -150};

  always #5 clk = ~clk;

  pid_cntrl_param dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .err(err), .P_gain(P_gain), .D_gain(D_gain),
    .pwr_up(pwr_up), .rider_off(rider_off), .hold(hold), .cntrl(cntrl),
    .cntrl_vld(cntrl_vld), .ss_tmr(ss_tmr), .int_sat(int_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rider_clr();
    rider_off = 1'b1;
    step();
    rider_off = 1'b0;
  endtask

  task automatic sample(input int e, input int exp, input string tag);
    err = 16'(e);
    vld = 1'b1;
    step();
    vld = 1'b0;
    chk({tag, ".lat1"}, int'(cntrl_vld), 0);
    step();
    chk({tag, ".vld"}, int'(cntrl_vld), 1);
    chk(tag, int'(cntrl), exp);
    step();
    chk({tag, ".pulse"}, int'(cntrl_vld), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b0; hold = 1'b0;
    err = '0; P_gain = '0; D_gain = '0;
    step(); step();
    chk("rst.cntrl", int'(cntrl), 0);
    chk("rst.vld", int'(cntrl_vld), 0);
    chk("rst.ss_tmr", int'(ss_tmr), 0);
    chk("rst.int_sat", int'(int_sat), 0);
    rst_n = 1'b1;
    step();

    P_gain = 6'd12;
    sample(16, 0, "idle");
    rider_clr();

    pwr_up = 1'b1;
    repeat (2047) step();
    chk("ss.pre", int'(ss_tmr), 0);
    step();
    chk("ss.first", int'(ss_tmr), 1);

    force dut.tmr_q = 27'h400_0000;
    step();
    chk("ramp.ss", int'(ss_tmr), 128);
    rider_clr();
    sample(32, 200, "ramp.half");
    rider_clr();
    P_gain = 6'd1;
    sample(-3, -3, "ramp.floor");

    force dut.tmr_q = 27'h7FF_FF00;
    step();
    release dut.tmr_q;
    step(); step();
    chk("ss.full", int'(ss_tmr), 255);

    rider_clr();
    P_gain = 6'd12;
    sample(16, 200, "run.p");
    rider_clr();
    sample(32767, 2047, "run.pos_sat");
    rider_clr();
    sample(-32768, -2048, "run.neg_sat");
    rider_clr();
    P_gain = 6'd1;
    sample(512, 766, "run.errsat_hi");
    rider_clr();
    sample(-513, -768, "run.errsat_lo");

    rider_clr();
    P_gain = 6'd0; D_gain = 6'd2;
    for (int i = 0; i < 9; i++) sample(d_err[i], d_exp[i], $sformatf("dhist%0d", i));

    rider_clr();
    D_gain = 6'd0;
    sample(100, 50, "hold.a");
    hold = 1'b1;
    sample(100, 50, "hold.b");
    hold = 1'b0;
    sample(100, 100, "hold.c");

    rider_clr();
    err = 16'h7FFF; vld = 1'b1; pulses = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (cntrl_vld) pulses++;
    end
    vld = 1'b0;
    step();
    if (cntrl_vld) pulses++;
    chk("isat.last", int'(cntrl), 2047);
    chk("isat.flag0", int'(int_sat), 0);
    step();
    if (cntrl_vld) pulses++;
    chk("b2b.pulses", pulses, 256);
    sample(32767, 2047, "isat.ovf");
    chk("isat.flag1", int'(int_sat), 1);
    sample(-32768, 2047, "isat.held");
    chk("isat.flag2", int'(int_sat), 0);

    rider_off = 1'b1; vld = 1'b1; err = 16'd100;
    step();
    rider_off = 1'b0; vld = 1'b0; pulses = 0;
    chk("roff.isat", int'(int_sat), 0);
    repeat (3) begin
      step();
      if (cntrl_vld) pulses++;
    end
    chk("roff.drop", pulses, 0);
    P_gain = 6'd12; D_gain = 6'd2;
    sample(0, 0, "roff.zero");

    D_gain = 6'd0;
    rider_clr();
    err = 16'd16; vld = 1'b1;
    step();
    vld = 1'b0; rider_off = 1'b1;
    step();
    rider_off = 1'b0;
    chk("inflight.vld", int'(cntrl_vld), 1);
    chk("inflight.cntrl", int'(cntrl), 200);

    pwr_up = 1'b0;
    step();
    chk("pdn.ss", int'(ss_tmr), 0);
    rider_clr();
    sample(16, 0, "pdn.idle");

    err = 16'd16; vld = 1'b1;
    step();
    vld = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst.vld0", int'(cntrl_vld), 0);
    step();
    chk("arst.vld1", int'(cntrl_vld), 0);
    rst_n = 1'b1;
    step();
    chk("arst.vld2", int'(cntrl_vld), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
